// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data plus redirect input and the
// registered valid/ready stream toward decode. The fetch unit is the master side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH = 16
);
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_instr, out_ready,
        output imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_instr, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch stage with redirect/flush and start/halt control.
// Define FETCH_PERF_CNT_EN to add saturating fetch_count/stall_count outputs.
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    fetch_unit_if.master        bus,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]         fetch_count,
    output logic [15:0]         stall_count,
`endif
    output logic                running
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   out_valid_q, out_valid_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic                   running_q, running_d;
    logic                   load;

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;
    assign running       = running_q;

    // A redirect suppresses the fetch so the stale word at pc is never emitted.
    assign load = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready)
                  && !bus.redirect_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start && !halt_req) state_d = ST_RUN;
            ST_RUN:    if (halt_req)           state_d = ST_HALTED;
            ST_HALTED: if (start && !halt_req) state_d = ST_RUN;
            default:                           state_d = ST_IDLE;
        endcase

        pc_d = pc_q;
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        else if (load)          pc_d = pc_q + ADDR_WIDTH'(1);

        out_valid_d = out_valid_q;
        if (bus.redirect_valid)  out_valid_d = 1'b0;
        else if (load)           out_valid_d = 1'b1;
        else if (bus.out_ready)  out_valid_d = 1'b0;

        out_instr_d = load ? bus.imem_instr : out_instr_q;
        out_pc_d    = load ? pc_q           : out_pc_q;
        running_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            running_q   <= running_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q, stall_count_q;
    logic        stall;

    assign stall       = out_valid_q && !bus.out_ready;
    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (load && fetch_count_q != 16'hFFFF)
                fetch_count_q <= fetch_count_q + 16'd1;
            if (stall && stall_count_q != 16'hFFFF)
                stall_count_q <= stall_count_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, wrap, halt and
// asynchronous reset against hand-computed expected words.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic halt_req;
    logic running;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1023];

    fetch_unit_if #(.ADDR_WIDTH(10), .INSTR_WIDTH(16)) bus ();

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .bus         (bus),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count (fetch_count),
        .stall_count (stall_count),
`endif
        .running     (running)
    );

    always #5 clk = ~clk;

    assign bus.imem_instr = mem[bus.imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                           input logic [9:0] pc, input logic [9:0] addr);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        if (v) begin
            chk({tag, ".instr"}, 32'(bus.out_instr), 32'(ins));
            chk({tag, ".pc"},    32'(bus.out_pc),    32'(pc));
        end
        chk({tag, ".addr"}, 32'(bus.imem_addr), 32'(addr));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'hF000 | 16'(i);
        mem[0] = 16'h2C03;
        mem[1] = 16'h8180;
        mem[2] = 16'h2404;
        mem[3] = 16'h0083;

        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b1;
        tick(); tick();
        chk("rst.valid",   32'(bus.out_valid), 32'd0);
        chk("rst.instr",   32'(bus.out_instr), 32'd0);
        chk("rst.pc",      32'(bus.out_pc),    32'd0);
        chk("rst.addr",    32'(bus.imem_addr), 32'd0);
        chk("rst.running", 32'(running),       32'd0);
        rst_n = 1'b1;
        tick();
        chk_out("idle", 1'b0, 16'h0, 10'd0, 10'd0);

        // Start: RUN entered, first word appears the cycle after.
        start = 1'b1; tick(); start = 1'b0;
        chk("start.running", 32'(running), 32'd1);
        chk_out("start", 1'b0, 16'h0, 10'd0, 10'd0);
        tick(); chk_out("s0", 1'b1, 16'h2C03, 10'd0, 10'd1);
        tick(); chk_out("s1", 1'b1, 16'h8180, 10'd1, 10'd2);

        // Three stalled cycles on the pc=1 word.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("stall", 1'b1, 16'h8180, 10'd1, 10'd2);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf.stall", 32'(stall_count), 32'd3);
        chk("perf.fetch", 32'(fetch_count), 32'd2);
`endif
        bus.out_ready = 1'b1;
        tick(); chk_out("s2", 1'b1, 16'h2404, 10'd2, 10'd3);
        tick(); chk_out("s3", 1'b1, 16'h0083, 10'd3, 10'd4);

        // Get the pc=1 word valid, then redirect to 3 while it is stalled.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 10'd1;
        tick(); bus.redirect_valid = 1'b0;
        chk_out("rd1.flush", 1'b0, 16'h0, 10'd0, 10'd1);
        tick(); chk_out("rd1.word", 1'b1, 16'h8180, 10'd1, 10'd2);
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 10'd3;
        tick(); bus.redirect_valid = 1'b0;
        chk_out("rd3.flush", 1'b0, 16'h0, 10'd0, 10'd3);
        tick(); chk_out("rd3.word", 1'b1, 16'h0083, 10'd3, 10'd4);
        bus.out_ready = 1'b1;

        // Wrap from 1023 to 0.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 10'd1023;
        tick(); bus.redirect_valid = 1'b0;
        chk_out("wrap.flush", 1'b0, 16'h0, 10'd0, 10'd1023);
        tick(); chk_out("wrap.1023", 1'b1, 16'hF3FF, 10'd1023, 10'd0);
        tick(); chk_out("wrap.0", 1'b1, 16'h2C03, 10'd0, 10'd1);

        // Halt while streaming: one final load, then the word waits.
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("halt.running", 32'(running), 32'd0);
        chk_out("halt.last", 1'b1, 16'h8180, 10'd1, 10'd2);
        bus.out_ready = 1'b0;
        tick(); tick();
        chk_out("halt.hold", 1'b1, 16'h8180, 10'd1, 10'd2);
        bus.out_ready = 1'b1;
        tick(); chk_out("halt.drain", 1'b0, 16'h0, 10'd0, 10'd2);
        tick(); chk_out("halt.frozen", 1'b0, 16'h0, 10'd0, 10'd2);
        start = 1'b1; halt_req = 1'b1; tick(); start = 1'b0; halt_req = 1'b0;
        chk("both.running", 32'(running), 32'd0);
        chk_out("both", 1'b0, 16'h0, 10'd0, 10'd2);
        start = 1'b1; tick(); start = 1'b0;
        chk("resume.running", 32'(running), 32'd1);
        tick(); chk_out("resume.2", 1'b1, 16'h2404, 10'd2, 10'd3);
        tick(); chk_out("resume.3", 1'b1, 16'h0083, 10'd3, 10'd4);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid",   32'(bus.out_valid), 32'd0);
        chk("arst.running", 32'(running),       32'd0);
        chk("arst.addr",    32'(bus.imem_addr), 32'd0);
        tick(); rst_n = 1'b1;
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        tick(); tick();
        chk("arst.idle.running", 32'(running), 32'd0);
        chk_out("arst.idle", 1'b0, 16'h0, 10'd0, 10'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); chk_out("arst.s0", 1'b1, 16'h2C03, 10'd0, 10'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch stage; sits directly upstream of instruction_memory.
- Drives the 10-bit fetch address and captures the 16-bit instruction returned combinationally by the memory.
- Presents {instruction, pc} to decode through a registered valid/ready output stage.
- Supports branch/jump redirect with flush, and start/halt control from the top-level sequencer.

Parameters:
- ADDR_WIDTH, 10, program counter and memory address width.
- INSTR_WIDTH, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; leaves IDLE or HALTED and enters RUN.
- halt_req  input  1  pulse; RUN -> HALTED.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDR_WIDTH  target PC.
- imem_addr  output  ADDR_WIDTH  address to instruction_memory; equals pc, combinational from the PC register.
- imem_instr  input  INSTR_WIDTH  instruction from memory, valid in the same cycle as imem_addr.
- out_valid  output  1  decode-stage data valid.
- out_ready  input  1  decode accepts the current word.
- out_instr  output  INSTR_WIDTH  fetched instruction.
- out_pc  output  ADDR_WIDTH  address of out_instr.
- running  output  1  high when state is RUN.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - pc = RESET_PC; state = IDLE.
  - out_valid = 0, out_instr = 0, out_pc = 0, running = 0.
- States:
  - IDLE: after reset; no fetch. start -> RUN.
  - RUN: fetches. halt_req -> HALTED.
  - HALTED: no fetch. start -> RUN.
- Fetch (load) condition: state == RUN and (out_valid == 0 or out_ready == 1) and redirect_valid == 0.
- On load:
  - out_instr <= imem_instr; out_pc <= pc; out_valid <= 1; pc <= pc + 1.
- Fetch-to-output latency: 1 cycle.
- Throughput: 1 instruction/cycle while out_ready is held high.
- Consume without reload (out_valid && out_ready, load condition false): out_valid <= 0.
- Stall (out_valid && !out_ready):
  - out_instr, out_pc and pc hold.
  - out_instr and out_pc are stable while out_valid is high and out_ready is low.
- Redirect (redirect_valid high, any state):
  - pc <= redirect_pc; out_valid <= 0 (flush), regardless of out_ready.
  - No fetch in that cycle.
  - First fetch from the target occurs on the next cycle if the state is RUN.
- PC arithmetic: modulo 2^ADDR_WIDTH; pc 1023 + 1 -> 0, with no flag.
- Halt:
  - In the halt_req cycle, a load proceeds if the load condition holds; the state becomes HALTED afterwards.
  - In HALTED, a pending out_valid word stays until accepted; pc is frozen.
- Simultaneous events:
  - halt_req and start in the same cycle: halt_req wins; RUN -> HALTED, HALTED stays HALTED, IDLE stays IDLE.
  - redirect_valid and halt_req: both applied (pc redirected, flushed, state HALTED).
  - start in RUN: ignored.
  - halt_req in IDLE: ignored.
- Reset mid-operation: all state clears immediately; in-flight word discarded.
- running = (state == RUN), registered.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_count, 16 bits: increments on every load.
  - stall_count, 16 bits: increments each cycle with out_valid && !out_ready.
  - Both reset to 0 and saturate at 16'hFFFF.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Bench memory image: addr0=0x2C03, addr1=0x8180, addr2=0x2404, addr3=0x0083.
- Reset, start pulse, out_ready=1 -> out_valid rises 1 cycle after RUN; out_instr/out_pc sequence (0x2C03,0), (0x8180,1), (0x2404,2), (0x0083,3) on consecutive cycles; imem_addr leads out_pc by 1.
- After word at pc=1 becomes valid, drop out_ready for 3 cycles -> out_instr=0x8180 and out_pc=1 held, imem_addr=2 held. Raise out_ready -> next word (0x2404,2) with no duplicate or skip. With FETCH_PERF_CNT_EN, stall_count=3.
- Redirect to 3 while out_valid holds pc=1 and out_ready=0 -> next cycle out_valid=0; following cycle (0x0083,3) valid.
- Redirect to 1023 -> out_pc=1023 then out_pc=0 (wrap), imem_addr=0 then 1.
- halt_req during streaming -> one final load allowed, running=0, word remains until accepted, then out_valid=0 and pc frozen. Simultaneous start+halt_req keeps HALTED. A later start resumes from the frozen pc.
- Assert rst_n low mid-stream (asynchronously, between edges) -> out_valid=0, running=0, imem_addr=RESET_PC immediately. No fetch until start.
